// File: rtl/uart_wb_pkg.sv
// uart_wb_pkg: shared command/status bytes and FSM encoding for the UART Wishbone master
package uart_wb_pkg;

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ST_ACK = 8'h4B;
    localparam logic [7:0] ST_ERR = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_STB,
        S_WAIT,
        S_RESP
    } state_t;

endpackage

// File: rtl/uart_wb_master.sv
// uart_wb_master: turns UART command frames into single Wishbone pipelined transactions and replies
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_byte_i,
    input  logic        rx_valid_i,
    output logic [7:0]  tx_byte_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i,
    output logic        busy_o
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_t        state;
    logic          wr_q;
    logic [1:0]    cnt;
    logic [TW-1:0] tmo;
    logic [7:0]    st_q;
    logic [31:0]   rdat_q;
    logic [2:0]    left;
    logic          ok;
    logic          done;

    assign wb_sel_o = 4'hF;
    assign busy_o   = state != S_IDLE;
    // err overrides ack; a timeout ends the cycle as an error
    assign ok       = wb_ack_i & ~wb_err_i;
    assign done     = wb_ack_i | wb_err_i | (tmo == TW'(TIMEOUT - 1));

    // frame parsing, bus cycle control and response serialisation
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            wr_q       <= 1'b0;
            cnt        <= 2'd0;
            tmo        <= '0;
            st_q       <= 8'h00;
            rdat_q     <= 32'h0;
            left       <= 3'd0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= 32'h0;
            wb_dat_o   <= 32'h0;
            tx_byte_o  <= 8'h00;
            tx_valid_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid_i && (rx_byte_i == CMD_WR || rx_byte_i == CMD_RD)) begin
                        wr_q  <= rx_byte_i == CMD_WR;
                        cnt   <= 2'd0;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_valid_i) begin
                        wb_adr_o <= {wb_adr_o[23:0], rx_byte_i};
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state    <= wr_q ? S_WDATA : S_STB;
                            wb_cyc_o <= !wr_q;
                            wb_stb_o <= !wr_q;
                            wb_we_o  <= 1'b0;
                            tmo      <= '0;
                        end
                    end
                end
                S_WDATA: begin
                    if (rx_valid_i) begin
                        wb_dat_o <= {wb_dat_o[23:0], rx_byte_i};
                        cnt      <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state    <= S_STB;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
                            wb_we_o  <= 1'b1;
                            tmo      <= '0;
                        end
                    end
                end
                S_STB, S_WAIT: begin
                    if (done) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        st_q     <= ok ? ST_ACK : ST_ERR;
                        rdat_q   <= (ok && !wr_q) ? wb_dat_i : 32'h0;
                        left     <= (ok && !wr_q) ? 3'd5 : 3'd1;
                        state    <= S_RESP;
                    end else begin
                        tmo <= tmo + TW'(1);
                        if (state == S_STB && !wb_stall_i) begin
                            wb_stb_o <= 1'b0;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_RESP: begin
                    if (!tx_valid_o) begin
                        tx_valid_o     <= 1'b1;
                        tx_byte_o      <= st_q;
                        {st_q, rdat_q} <= {rdat_q, 8'h00};
                        left           <= left - 3'd1;
                    end else if (tx_ready_i) begin
                        tx_valid_o <= 1'b0;
                        if (left == 3'd0) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master: scoreboard bench driving UART frames and a scripted Wishbone slave
module tb_uart_wb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  tx_byte_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i = 1'b0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [31:0] wb_dat_i = 32'h0;
    logic        busy_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];

    uart_wb_master #(.TIMEOUT(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .rx_byte_i(rx_byte_i), .rx_valid_i(rx_valid_i),
        .tx_byte_o(tx_byte_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_dat_i(wb_dat_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input bit wr, input logic [31:0] adr, input logic [31:0] dat);
        send_byte(wr ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
        if (wr) for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8]);
    endtask

    task automatic slave(input bit wr, input logic [31:0] adr, input logic [31:0] dat,
                         input int stall_n, input int mode, input int resp_at,
                         input logic [31:0] rdata, input int exp_stb, input int exp_cyc);
        int k = 0, w = 0, sn = 0, cn = 0;
        while (!wb_cyc_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("cyc_start", wb_cyc_o, 1);
        while (wb_cyc_o && k < 100) begin
            cn++;
            if (wb_stb_o) sn++;
            if (k == 0) begin
                chk("adr", wb_adr_o, adr);
                chk("we", wb_we_o, wr);
                chk("sel", wb_sel_o, 4'hF);
                if (wr) chk("dat", wb_dat_o, dat);
            end
            wb_stall_i = k < stall_n;
            wb_ack_i   = mode == 0 && k == resp_at;
            wb_err_i   = mode == 1 && k == resp_at;
            wb_dat_i   = rdata;
            @(negedge clk);
            k++;
        end
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        chk("stb_cycles", sn, exp_stb);
        chk("cyc_cycles", cn, exp_cyc);
    endtask

    task automatic drain(input int low_n);
        int low = 0;
        bit held = 0;
        logic [7:0] hb = 8'h00;
        logic [7:0] e;
        for (int i = 0; i < 200 && q.size() > 0; i++) begin
            if (tx_valid_o) begin
                tx_ready_i = low >= low_n;
                if (held) chk("tx_hold", tx_byte_o, hb);
                if (tx_ready_i) begin
                    e = q.pop_front();
                    chk("tx_byte", tx_byte_o, e);
                    held = 0;
                end else begin
                    low++;
                    held = 1;
                    hb = tx_byte_o;
                end
            end else begin
                tx_ready_i = 1'b0;
            end
            @(negedge clk);
        end
        tx_ready_i = 1'b0;
        chk("tx_left", q.size(), 0);
        repeat (2) @(negedge clk);
        chk("tx_idle", tx_valid_o, 0);
        chk("busy_idle", busy_o, 0);
    endtask

    task automatic txn(input bit wr, input logic [31:0] adr, input logic [31:0] dat,
                       input int stall_n, input int mode, input int resp_at, input logic [31:0] rdata,
                       input int exp_stb, input int exp_cyc, input int low_n);
        if (mode == 0) begin
            q.push_back(8'h4B);
            if (!wr) for (int i = 3; i >= 0; i--) q.push_back(rdata[i*8 +: 8]);
        end else begin
            q.push_back(8'h45);
        end
        send_frame(wr, adr, dat);
        slave(wr, adr, dat, stall_n, mode, resp_at, rdata, exp_stb, exp_cyc);
        drain(low_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_txv", tx_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_txb", tx_byte_o, 0);
        rst = 1'b0;
        @(negedge clk);
        txn(1, 32'h0000_8010, 32'hDEAD_BEEF, 0, 0, 2, 32'h0, 1, 3, 0);
        txn(0, 32'h0000_7400, 32'h0, 3, 0, 4, 32'h1234_5678, 4, 5, 0);
        txn(0, 32'h0000_8014, 32'h0, 0, 1, 1, 32'hFFFF_FFFF, 1, 2, 0);
        txn(0, 32'h0000_9000, 32'h0, 0, 2, 0, 32'h0, 1, 16, 0);
        send_byte(8'h41);
        chk("discard_busy", busy_o, 0);
        txn(0, 32'hA000_0004, 32'h0, 0, 0, 1, 32'hA5C3_0F96, 1, 2, 5);
        send_frame(0, 32'h0000_0100, 32'h0);
        repeat (3) @(negedge clk);
        chk("pre_rst_cyc", wb_cyc_o, 1);
        rst = 1'b1;
        #1;
        chk("arst_cyc", wb_cyc_o, 0);
        chk("arst_stb", wb_stb_o, 0);
        chk("arst_txv", tx_valid_o, 0);
        chk("arst_busy", busy_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        txn(0, 32'h0000_0200, 32'h0, 0, 0, 0, 32'hCAFE_F00D, 1, 1, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_wb_master.md
UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 Parameter TIMEOUT, default 1024: maximum number of cycles cyc_o may stay high per transaction; legal range is 2 or more.
REQ-002 wb_clk_i  in  1  system clock; all state updates on the rising edge.
REQ-003 wb_rst_i  in  1  reset: asynchronous, active-high.
REQ-004 rx_byte_i  in  8  received UART byte.
REQ-005 rx_valid_i  in  1  single-cycle pulse; rx_byte_i is valid in that cycle.
REQ-006 tx_byte_o  out  8  response byte to the UART transmitter.
REQ-007 tx_valid_o  out  1  tx_byte_o valid; held with tx_byte_o stable until accepted.
REQ-008 tx_ready_i  in  1  transmitter accepts tx_byte_o on any edge where tx_valid_o and tx_ready_i are both 1.
REQ-009 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone pipelined master controls.
REQ-010 wb_adr_o, wb_dat_o  out  32 each  address and write data.
REQ-011 wb_sel_o  out  4  byte selects; constant 4'hF.
REQ-012 wb_stall_i, wb_ack_i, wb_err_i  in  1 each  slave responses.
REQ-013 wb_dat_i  in  32  read data.
REQ-014 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-015 Command frames on rx, bytes sent MSB first:
- Write: 0x57, ADR[31:24..7:0], DAT[31:24..7:0] (9 bytes).
- Read: 0x52, ADR (4 bytes) (5 bytes).
REQ-016 States and transitions:
- IDLE: on 0x57 or 0x52 go to ADDR.
- ADDR: after 4 bytes, go to WDATA (write) or STB (read).
- WDATA: after 4 bytes, go to STB.
- STB: go to WAIT when stall is 0.
- WAIT: go to RESP on ack or err.
- RESP: go to IDLE when the last response byte is accepted.
REQ-017 In IDLE, any byte other than 0x57 or 0x52 is discarded and the state is unchanged.
REQ-018 rx_valid_i pulses while in STB, WAIT or RESP are discarded.
REQ-019 Address and data are assembled by shifting left 8 bits per byte; a 2-bit byte counter wraps 3 to 0.
REQ-020 Entering STB: cyc_o=1 and stb_o=1; we_o=1 for write, 0 for read; adr_o and dat_o hold the assembled values.
REQ-021 stb_o stays high through every cycle where stall_i=1; it drops the cycle after the first edge where stall_i=0.
REQ-022 ack_i and err_i are sampled on every edge where cyc_o=1, including the strobe-accept edge. A response ends the cycle: cyc_o goes 0 on the next cycle. If ack and err are both high, err wins.
REQ-023 On a read ack, wb_dat_i is captured into a 32-bit response register on that same edge.
REQ-024 A timeout counter clears when cyc_o rises and increments each cycle cyc_o is high. If it reaches TIMEOUT-1 with no ack or err, cyc_o and stb_o drop and the transaction is treated as an error. cyc_o is therefore never high for more than TIMEOUT cycles.
REQ-025 Response bytes:
- Write: a single status byte, 0x4B for ack, 0x45 for err or timeout.
- Read ack: 0x4B followed by read data MSB first (5 bytes).
- Read err or timeout: 0x45 only.
REQ-026 tx_valid_o rises the cycle after RESP is entered. After each accept, the next byte is presented on the following cycle (one idle cycle between bytes is permitted). tx_valid_o goes 0 after the final accept.
REQ-027 Exactly one Wishbone transaction is issued per valid frame; cyc_o is 0 whenever the state is IDLE, ADDR, WDATA or RESP.

Reset
REQ-028 On wb_rst_i=1, immediately and regardless of state (including mid-transaction or mid-response):
- state=IDLE;
- cyc_o, stb_o, we_o, tx_valid_o and busy_o = 0;
- adr_o, dat_o, tx_byte_o, counters and the response register = 0;
- any partial frame is discarded.
REQ-029 After reset release, the first rx byte is interpreted as a command byte.

Structure
REQ-030 Command bytes (0x57, 0x52), status bytes (0x4B, 0x45) and the state encoding SHALL live in shared package uart_wb_pkg.
REQ-031 The block SHALL be a single flat module with no sub-modules; the timeout counter is $clog2(TIMEOUT)+1 bits wide.

Verification
REQ-032 Write flow:
- Stimulus: rx 57 00 00 80 10 DE AD BE EF; ack 2 cycles after strobe.
- Response: one cycle with adr=0x8010, dat=0xDEADBEEF, we=1, sel=F; tx 4B.
REQ-033 Read with stall:
- Stimulus: rx 52 00 00 74 00; stall=1 for 3 cycles; then ack with dat_i=0x12345678.
- Response: stb high exactly 4 cycles; tx 4B 12 34 56 78.
REQ-034 Read error: rx 52 00 00 80 14, slave asserts err -> tx 45 only; cyc drops the next cycle.
REQ-035 Timeout: TIMEOUT=16, no ack or err -> cyc high exactly 16 cycles, then tx 45.
REQ-036 Discard and backpressure:
- Stimulus: rx 41, then a valid read; tx_ready_i=0 for 5 cycles during the response.
- Response: 0x41 is ignored; tx_byte_o is held stable until accepted; no bytes are lost.
REQ-037 Reset during WAIT -> cyc, stb and tx_valid go 0 in the same cycle; a following read frame completes normally.
